// File: rtl/clic_gateway_if.sv
// clic_gateway_if: per-source signal bundle between the gateway and the
// logic around it (trigger configuration, arbiter claims, software access).
//
// Parameter: N_SOURCE - number of interrupt sources.
//
// Signals (all N_SOURCE wide; one bit per source):
//   intr_src_i    raw interrupt lines (may be asynchronous)
//   trig_edge_i   1 = edge-triggered, 0 = level-triggered
//   trig_neg_i    1 = active-low / falling edge, 0 = active-high / rising edge
//   claim_i       one-cycle claim pulse from the arbiter (at most one bit set)
//   ip_sw_we_i    software write strobe for the pending bit
//   ip_sw_wdata_i software write value
//   ovf_clr_i     clear strobe for the sticky overflow flag
//   ip_o          registered pending bits to the arbiter
//   le_o          copy of trig_edge_i for the arbiter
//   ovf_o         sticky overflow flags
//
// Handshake: there is no valid/ready pair. claim_i, ip_sw_we_i and ovf_clr_i
// are single-cycle strobes that act on the clock edge they are sampled on;
// their effect on ip_o/ovf_o is visible one cycle later.
//
// Modports: slave = the gateway, master = the surrounding logic/arbiter.
interface clic_gateway_if #(
  parameter int N_SOURCE = 256
);
  logic [N_SOURCE-1:0] intr_src_i;
  logic [N_SOURCE-1:0] trig_edge_i;
  logic [N_SOURCE-1:0] trig_neg_i;
  logic [N_SOURCE-1:0] claim_i;
  logic [N_SOURCE-1:0] ip_sw_we_i;
  logic [N_SOURCE-1:0] ip_sw_wdata_i;
  logic [N_SOURCE-1:0] ovf_clr_i;
  logic [N_SOURCE-1:0] ip_o;
  logic [N_SOURCE-1:0] le_o;
  logic [N_SOURCE-1:0] ovf_o;

  modport slave (
    input  intr_src_i, trig_edge_i, trig_neg_i, claim_i,
           ip_sw_we_i, ip_sw_wdata_i, ovf_clr_i,
    output ip_o, le_o, ovf_o
  );

  modport master (
    output intr_src_i, trig_edge_i, trig_neg_i, claim_i,
           ip_sw_we_i, ip_sw_wdata_i, ovf_clr_i,
    input  ip_o, le_o, ovf_o
  );
endinterface

// File: rtl/clic_gateway.sv
// clic_gateway: per-source interrupt gateway in front of the CLIC arbiter.
// Synchronises the raw lines, applies level/edge and polarity per source,
// keeps the pending bits (ip_o) and flags edges that arrive while a source
// is already pending (ovf_o). Sources are fully independent.
//
// Parameters:
//   N_SOURCE   number of sources (>= 2)
//   SyncStages synchroniser depth; 0 = inputs already synchronous
//
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     clic_gateway_if.slave (see interface for signal list)
module clic_gateway #(
  parameter int N_SOURCE   = 256,
  parameter int SyncStages = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  clic_gateway_if.slave  bus
);

  logic [N_SOURCE-1:0] s;         // synchronised line level
  logic [N_SOURCE-1:0] p_d, p_q;  // previous synchronised level (un-polarised)
  logic [N_SOURCE-1:0] ip_d, ip_q;
  logic [N_SOURCE-1:0] ovf_d, ovf_q;
  logic [N_SOURCE-1:0] act;       // level after polarity
  logic [N_SOURCE-1:0] edge_det;  // inactive-to-active transition this cycle

  // Synchroniser chain
  if (SyncStages > 0) begin : g_sync
    logic [N_SOURCE-1:0] sync_d [SyncStages];
    logic [N_SOURCE-1:0] sync_q [SyncStages];

    always_comb begin
      sync_d[0] = bus.intr_src_i;
      for (int k = 1; k < SyncStages; k++) begin
        sync_d[k] = sync_q[k-1];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int k = 0; k < SyncStages; k++) begin
          sync_q[k] <= '0;
        end
      end else begin
        for (int k = 0; k < SyncStages; k++) begin
          sync_q[k] <= sync_d[k];
        end
      end
    end

    assign s = sync_q[SyncStages-1];
  end else begin : g_nosync
    assign s = bus.intr_src_i;
  end

  // Both s and p are polarised with the current trig_neg, so flipping the
  // polarity on a static line moves both sides together and never looks
  // like an edge.
  assign act      = s ^ bus.trig_neg_i;
  assign edge_det = act & ~(p_q ^ bus.trig_neg_i);

  always_comb begin
    p_d   = s;
    ip_d  = ip_q;
    ovf_d = ovf_q;
    for (int i = 0; i < N_SOURCE; i++) begin
      if (!bus.trig_edge_i[i]) begin
        // Level mode: pending simply mirrors the active level.
        ip_d[i] = act[i];
      end else if (edge_det[i]) begin
        ip_d[i] = 1'b1;
      end else if (bus.ip_sw_we_i[i]) begin
        ip_d[i] = bus.ip_sw_wdata_i[i];
      end else if (bus.claim_i[i]) begin
        ip_d[i] = 1'b0;
      end

      // An edge that coincides with a claim re-arms rather than overflows.
      // Set beats clear so a lost edge is never silently dropped.
      if (bus.trig_edge_i[i] && edge_det[i] && ip_q[i] && !bus.claim_i[i]) begin
        ovf_d[i] = 1'b1;
      end else if (bus.ovf_clr_i[i]) begin
        ovf_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_q   <= '0;
      ip_q  <= '0;
      ovf_q <= '0;
    end else begin
      p_q   <= p_d;
      ip_q  <= ip_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.ip_o  = ip_q;
  assign bus.ovf_o = ovf_q;
  assign bus.le_o  = bus.trig_edge_i;

  // The arbiter claims one source at a time.
  claim_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(bus.claim_i));

endmodule

// File: tb/tb_clic_gateway.sv
module tb_clic_gateway;
  localparam int N = 256;

  // clock / reset
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  clic_gateway_if #(.N_SOURCE(N)) bus ();

  clic_gateway #(.N_SOURCE(N), .SyncStages(2)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [N-1:0] exp_edge;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance n clock edges, then sit 1 time unit after the last edge
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // one-cycle strobe helpers
  task automatic claim(input int src);
    bus.claim_i[src] = 1'b1;
    step();
    bus.claim_i[src] = 1'b0;
  endtask

  task automatic sw_write(input int src, input logic val);
    bus.ip_sw_we_i[src]    = 1'b1;
    bus.ip_sw_wdata_i[src] = val;
    step();
    bus.ip_sw_we_i[src]    = 1'b0;
    bus.ip_sw_wdata_i[src] = 1'b0;
  endtask

  initial begin
    bus.intr_src_i    = '0;
    bus.trig_edge_i   = '0;
    bus.trig_neg_i    = '0;
    bus.claim_i       = '0;
    bus.ip_sw_we_i    = '0;
    bus.ip_sw_wdata_i = '0;
    bus.ovf_clr_i     = '0;
    // sources 0,1,5,7 edge mode; 3 level; 7 falling edge, idles high
    exp_edge = '0;
    exp_edge[0] = 1'b1;
    exp_edge[1] = 1'b1;
    exp_edge[5] = 1'b1;
    exp_edge[7] = 1'b1;
    bus.trig_edge_i   = exp_edge;
    bus.trig_neg_i[7] = 1'b1;
    bus.intr_src_i[7] = 1'b1;

    // ---- reset state ----
    step(2);
    check("reset_ip",  bus.ip_o,  '0);
    check("reset_ovf", bus.ovf_o, '0);
    check("reset_le",  bus.le_o,  exp_edge);
    rst_ni = 1'b1;
    step(5);
    check("idle_ip", bus.ip_o, '0);

    // ---- level, active-high, src 3 ----
    bus.intr_src_i[3] = 1'b1;
    step(2);
    check("lvl_rise_early", N'(bus.ip_o[3]), N'(0));
    step();
    check("lvl_rise", N'(bus.ip_o[3]), N'(1));
    claim(3);
    check("lvl_claim_ignored", N'(bus.ip_o[3]), N'(1));
    step();
    check("lvl_hold", N'(bus.ip_o[3]), N'(1));
    check("lvl_le", N'(bus.le_o[3]), N'(0));
    bus.intr_src_i[3] = 1'b0;
    step(2);
    check("lvl_fall_early", N'(bus.ip_o[3]), N'(1));
    step();
    check("lvl_fall", N'(bus.ip_o[3]), N'(0));
    sw_write(3, 1'b1);
    check("lvl_sw_ignored", N'(bus.ip_o[3]), N'(0));

    // ---- edge, rising, src 5: 3-cycle pulse ----
    bus.intr_src_i[5] = 1'b1;
    step(2);
    check("edge_rise_early", N'(bus.ip_o[5]), N'(0));
    step();
    check("edge_rise", N'(bus.ip_o[5]), N'(1));
    bus.intr_src_i[5] = 1'b0;
    step(4);
    check("edge_held", N'(bus.ip_o[5]), N'(1));
    claim(5);
    check("edge_claim", N'(bus.ip_o[5]), N'(0));
    check("edge_no_ovf", N'(bus.ovf_o[5]), N'(0));
    step(3);
    check("edge_stays_clr", N'(bus.ip_o[5]), N'(0));

    // ---- falling edge on src 7, then polarity flip ----
    bus.intr_src_i[7] = 1'b0;
    step(2);
    check("fall_early", N'(bus.ip_o[7]), N'(0));
    step();
    check("fall_set", N'(bus.ip_o[7]), N'(1));
    sw_write(7, 1'b0);
    check("fall_sw_clr", N'(bus.ip_o[7]), N'(0));
    bus.trig_neg_i[7] = 1'b0;
    step(3);
    check("flip_to_pos", N'(bus.ip_o[7]), N'(0));
    bus.trig_neg_i[7] = 1'b1;
    step(3);
    check("flip_to_neg", N'(bus.ip_o[7]), N'(0));

    // ---- overflow on src 1 ----
    bus.intr_src_i[1] = 1'b1;
    step(3);
    check("ovf_first_ip", N'(bus.ip_o[1]), N'(1));
    check("ovf_first_ovf", N'(bus.ovf_o[1]), N'(0));
    bus.intr_src_i[1] = 1'b0;
    step(3);
    bus.intr_src_i[1] = 1'b1;
    step(3);
    check("ovf_second_ovf", N'(bus.ovf_o[1]), N'(1));
    check("ovf_second_ip", N'(bus.ip_o[1]), N'(1));
    bus.ovf_clr_i[1] = 1'b1;
    step();
    bus.ovf_clr_i[1] = 1'b0;
    check("ovf_clear", N'(bus.ovf_o[1]), N'(0));
    // edge coinciding with claim: edge is seen on the 3rd clock after the rise
    bus.intr_src_i[1] = 1'b0;
    step(3);
    bus.intr_src_i[1] = 1'b1;
    step(2);
    claim(1);
    check("edge_claim_ip", N'(bus.ip_o[1]), N'(1));
    check("edge_claim_ovf", N'(bus.ovf_o[1]), N'(0));
    // clear together with a new overflow edge: set wins
    bus.intr_src_i[1] = 1'b0;
    step(3);
    bus.intr_src_i[1] = 1'b1;
    step(2);
    bus.ovf_clr_i[1] = 1'b1;
    step();
    bus.ovf_clr_i[1] = 1'b0;
    check("ovf_set_wins", N'(bus.ovf_o[1]), N'(1));
    check("ovf_set_wins_ip", N'(bus.ip_o[1]), N'(1));

    // ---- simultaneous strobes, src 5 (ip = 0, line low) ----
    bus.claim_i[5] = 1'b1;
    sw_write(5, 1'b1);
    bus.claim_i[5] = 1'b0;
    check("sw1_vs_claim", N'(bus.ip_o[5]), N'(1));
    claim(5);
    check("sim_reclaim", N'(bus.ip_o[5]), N'(0));
    bus.intr_src_i[5] = 1'b1;
    step(2);
    sw_write(5, 1'b0);
    check("sw0_vs_edge", N'(bus.ip_o[5]), N'(1));

    // ---- asynchronous reset mid-cycle ----
    bus.intr_src_i[0] = 1'b1;
    step(4);
    check("pre_rst_ip0", N'(bus.ip_o[0]), N'(1));
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_ip",  bus.ip_o,  '0);
    check("async_rst_ovf", bus.ovf_o, '0);
    step(2);
    rst_ni = 1'b1;
    step(2);
    check("rel_ip0_early", N'(bus.ip_o[0]), N'(0));
    step();
    check("rel_ip0_set", N'(bus.ip_o[0]), N'(1));
    claim(0);
    check("rel_ip0_claim", N'(bus.ip_o[0]), N'(0));
    step(5);
    check("rel_ip0_once", N'(bus.ip_o[0]), N'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
